// File: rtl/shift_tx_pkg.sv
// -----------------------------------------------------------------------------
// shift_tx_pkg
// Shared types and constants for the two-requester serial transmit scheduler.
//   state_e : FSM encoding (IDLE, SHIFT, PARITY)
//   REQ0/1  : requester id values as driven on sid
// -----------------------------------------------------------------------------
package shift_tx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/shift_tx_scheduler_if.sv
// -----------------------------------------------------------------------------
// shift_tx_scheduler_if
// Bundle of the two requester handshakes and the serial output side.
//   req0_valid/req0_data/req0_ready : requester 0 valid/ready word channel
//   req1_valid/req1_data/req1_ready : requester 1 valid/ready word channel
//   sdo, sframe, sid, done          : serial line, frame strobe, owner id, end pulse
// Modports: master = producer/sink side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface shift_tx_scheduler_if #(
    parameter int WIDTH = 4
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             sdo;
    logic             sframe;
    logic             sid;
    logic             done;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, sdo, sframe, sid, done
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, sdo, sframe, sid, done
    );
endinterface

// File: rtl/shift_tx_rr_arbiter.sv
// -----------------------------------------------------------------------------
// shift_tx_rr_arbiter
// Two-way combinational round-robin grant. The priority pointer is owned by
// the parent; this block only decides who wins this cycle.
//   i_valid[1:0] : requester valids
//   i_prio       : requester id that wins when both are valid
//   o_grant[1:0] : one-hot (or zero) grant vector
//   o_gnt_id     : id of the granted requester (0 when nothing granted)
// -----------------------------------------------------------------------------
module shift_tx_rr_arbiter
    import shift_tx_pkg::*;
(
    input  logic [1:0] i_valid,
    input  logic       i_prio,
    output logic [1:0] o_grant,
    output logic       o_gnt_id
);

    always_comb begin
        o_grant[0] = i_valid[0] & (~i_valid[1] | (i_prio == REQ0));
        o_grant[1] = i_valid[1] & (~i_valid[0] | (i_prio == REQ1));
        o_gnt_id   = o_grant[1] ? REQ1 : REQ0;
    end

endmodule

// File: rtl/shift_tx_scheduler.sv
// -----------------------------------------------------------------------------
// shift_tx_scheduler
// Round-robin scheduler for two parallel-word requesters feeding one serial
// line. The granted word is loaded into a left-shift register and sent
// MSB-first with a frame strobe and a one-cycle done pulse on the last cycle.
//   clk  : clock, all updates on rising edge
//   rstn : synchronous active-low reset
//   bus  : shift_tx_scheduler_if.slave (requester handshakes + serial outputs)
// Optional build macro SHIFT_TX_PARITY_EN appends an even-parity bit cycle
// after the data bits and moves done onto it.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | arbitrate, ready asserted for the winner, load on handshake
// SHIFT  | one data bit per cycle on sdo, counter counts down to 0
// PARITY | (macro only) single cycle carrying the even-parity bit
// -----------------------------------------------------------------------------
module shift_tx_scheduler
    import shift_tx_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    shift_tx_scheduler_if.slave  bus
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
    localparam logic [1:0]      ST_IDLE  = IDLE;
    localparam logic [1:0]      ST_SHIFT = SHIFT;
`ifdef SHIFT_TX_PARITY_EN
    localparam logic [1:0]      ST_PARITY = PARITY;
`endif

    logic [1:0]       r_state;
    logic             r_prio;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_sid;
    logic             r_sdo;
    logic             r_sframe;
    logic             r_done;
`ifdef SHIFT_TX_PARITY_EN
    logic             r_par;
`endif

    logic [1:0]       w_grant;
    logic             w_gnt_id;
    logic             w_hs;
    logic [WIDTH-1:0] w_gnt_data;

    shift_tx_rr_arbiter u_arb (
        .i_valid  ({bus.req1_valid, bus.req0_valid}),
        .i_prio   (r_prio),
        .o_grant  (w_grant),
        .o_gnt_id (w_gnt_id)
    );

    // Ready is only offered in IDLE and is gated by rstn so nothing is
    // accepted on a reset edge.
    assign w_hs       = (r_state == ST_IDLE) & rstn & (|w_grant);
    assign w_gnt_data = w_gnt_id ? bus.req1_data : bus.req0_data;

    assign bus.req0_ready = (r_state == ST_IDLE) & rstn & w_grant[0];
    assign bus.req1_ready = (r_state == ST_IDLE) & rstn & w_grant[1];
    assign bus.sdo        = r_sdo;
    assign bus.sframe     = r_sframe;
    assign bus.sid        = r_sid;
    assign bus.done       = r_done;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_prio   <= REQ0;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_sid    <= REQ0;
            r_sdo    <= 1'b0;
            r_sframe <= 1'b0;
            r_done   <= 1'b0;
`ifdef SHIFT_TX_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_shift  <= w_gnt_data;
                        r_cnt    <= CNT_LAST;
                        r_sid    <= w_gnt_id;
                        r_prio   <= ~w_gnt_id;
                        r_state  <= ST_SHIFT;
                        // Output flops lead the shift register by one
                        // cycle so the first bit appears in bit cycle 1.
                        r_sdo    <= w_gnt_data[WIDTH-1];
                        r_sframe <= 1'b1;
                        r_done   <= 1'b0;
`ifdef SHIFT_TX_PARITY_EN
                        r_par    <= ^w_gnt_data;
`endif
                    end
                end
                ST_SHIFT: begin
                    r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                    if (r_cnt == '0) begin
`ifdef SHIFT_TX_PARITY_EN
                        r_state  <= ST_PARITY;
                        r_sdo    <= r_par;
                        r_sframe <= 1'b1;
                        r_done   <= 1'b1;
`else
                        r_state  <= ST_IDLE;
                        r_sdo    <= 1'b0;
                        r_sframe <= 1'b0;
                        r_done   <= 1'b0;
`endif
                    end else begin
                        r_cnt    <= r_cnt - 1'b1;
                        r_sdo    <= r_shift[WIDTH-2];
                        r_sframe <= 1'b1;
`ifdef SHIFT_TX_PARITY_EN
                        r_done   <= 1'b0;
`else
                        // Next cycle is the last data bit.
                        r_done   <= (r_cnt == CW'(1));
`endif
                    end
                end
`ifdef SHIFT_TX_PARITY_EN
                ST_PARITY: begin
                    r_state  <= ST_IDLE;
                    r_sdo    <= 1'b0;
                    r_sframe <= 1'b0;
                    r_done   <= 1'b0;
                end
`endif
                default: begin
                    r_state  <= ST_IDLE;
                    r_sdo    <= 1'b0;
                    r_sframe <= 1'b0;
                    r_done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_shift_tx_scheduler
// Directed bench for shift_tx_scheduler: reset, single frame, contention,
// streaming and mid-frame reset. Parity frames are expected when built with
// SHIFT_TX_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_shift_tx_scheduler;
    import shift_tx_pkg::*;

    localparam int WIDTH = 4;
`ifdef SHIFT_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB = WIDTH + PAR;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   cyc  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shift_tx_scheduler_if #(.WIDTH(WIDTH)) bus ();

    shift_tx_scheduler #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Starts in the cycle before the IDLE grant cycle; returns at the
    // negedge of the frame's last cycle. start_cyc is the handshake edge.
    task automatic expect_frame(input logic id, input logic [WIDTH-1:0] data,
                                input bit drop, output int start_cyc);
        logic [WIDTH-1:0] d;
        d = data;
        @(negedge clk);
        check_eq("idle_sframe", 32'(bus.sframe), 32'd0);
        check_eq("idle_done",   32'(bus.done),   32'd0);
        check_eq("grant_rdy0",  32'(bus.req0_ready), 32'(id == REQ0));
        check_eq("grant_rdy1",  32'(bus.req1_ready), 32'(id == REQ1));
        @(posedge clk);
        #1;
        start_cyc = cyc;
        if (drop) begin
            if (id == REQ0) bus.req0_valid = 1'b0;
            else            bus.req1_valid = 1'b0;
        end
        for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            check_eq("bit_sframe", 32'(bus.sframe), 32'd1);
            if (k < WIDTH) check_eq("bit_sdo", 32'(bus.sdo), 32'(d[WIDTH-1-k]));
            else           check_eq("par_sdo", 32'(bus.sdo), 32'(^d));
            check_eq("bit_done", 32'(bus.done), 32'(k == NB - 1));
            check_eq("bit_sid",  32'(bus.sid),  32'(id));
            check_eq("bit_rdy",  32'(bus.req0_ready | bus.req1_ready), 32'd0);
            if (k < NB - 1) begin
                @(posedge clk);
            end
        end
    endtask

    initial begin
        int t, t0, t1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_data  = 4'hA;
        bus.req1_data  = 4'h5;
        rstn           = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_sdo",    32'(bus.sdo),    32'd0);
        check_eq("rst_sframe", 32'(bus.sframe), 32'd0);
        check_eq("rst_sid",    32'(bus.sid),    32'd0);
        check_eq("rst_done",   32'(bus.done),   32'd0);
        check_eq("rst_rdy0",   32'(bus.req0_ready), 32'd0);
        check_eq("rst_rdy1",   32'(bus.req1_ready), 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Contention from reset: req0 first, then req1, then req0 again.
        expect_frame(REQ0, 4'hA, 1'b1, t);
        expect_frame(REQ1, 4'h5, 1'b1, t);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_data  = 4'b1011;
        expect_frame(REQ0, 4'b1011, 1'b1, t);

        // Streaming on req1 with req0 idle.
        bus.req1_data = 4'h3;
        expect_frame(REQ1, 4'h3, 1'b0, t0);
        bus.req1_data = 4'hC;
        expect_frame(REQ1, 4'hC, 1'b1, t1);
        check_eq("stream_period", 32'(t1 - t0), 32'(NB + 1));

        // Reset two bits into a req0 frame of 4'hF (leaves prio pointing at req1).
        bus.req0_data  = 4'hF;
        bus.req0_valid = 1'b1;
        @(negedge clk);
        check_eq("mr_rdy0", 32'(bus.req0_ready), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("mr_b1_sdo", 32'(bus.sdo), 32'd1);
        check_eq("mr_b1_sframe", 32'(bus.sframe), 32'd1);
        @(negedge clk);
        check_eq("mr_b2_sdo", 32'(bus.sdo), 32'd1);
        @(posedge clk);
        #1;
        rstn           = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1;
        @(negedge clk);
        check_eq("mr_rst_rdy", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
        check_eq("mr_rst_done", 32'(bus.done), 32'd0);
        @(posedge clk);
        #1;
        rstn           = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_data  = 4'h9;
        // Post-reset IDLE: sframe already low, prio back to req0.
        expect_frame(REQ0, 4'h9, 1'b1, t);
        expect_frame(REQ1, 4'hC, 1'b1, t);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_tx_scheduler.md
# shift_tx_scheduler

Two-requester serial transmit scheduler built around a WIDTH-bit left-shift register. It arbitrates round-robin between two parallel-word requesters using valid/ready handshakes. It loads the granted word into the shift register and shifts it out MSB-first on a single serial line, with a frame strobe and a completion pulse. It sits between parallel producers and any single-bit serial sink in the design.

## Interface
- WIDTH, 4, data word width in bits (legal range ≥ 2).
- clk  in  1  clock; all state updates on posedge clk.
- rstn  in  1  reset, synchronous, active-low.
- req0_valid  in  1  requester 0 has a word.
- req0_data  in  WIDTH  requester 0 word; held stable while req0_valid is high and req0_ready is low.
- req0_ready  out  1  requester 0 word accepted this cycle.
- req1_valid  in  1  requester 1 has a word.
- req1_data  in  WIDTH  requester 1 word.
- req1_ready  out  1  requester 1 word accepted this cycle.
- sdo  out  1  serial data, MSB first.
- sframe  out  1  high during every serial bit cycle of a frame.
- sid  out  1  id of the requester owning the current or last frame.
- done  out  1  one-cycle pulse on the final bit cycle of a frame.

## Operation
- FSM states: IDLE, SHIFT, PARITY (PARITY exists only with the macro).
- IDLE:
  - Arbiter grants one valid requester. Priority pointer prio resets to 0.
  - With both valid, requester prio wins. With one valid, it wins regardless of prio.
  - reqN_ready = (state==IDLE) & rstn & grantN. Ready depends combinationally on both valids; no other combinational paths.
  - On handshake (valid & ready): shift register <= granted data, sid <= granted id, bit counter <= WIDTH-1, prio <= ~granted id, next state SHIFT.
- SHIFT:
  - sframe=1, sdo = shift register MSB.
  - Each cycle the register shifts left, filling with 0, and the counter decrements.
  - When the counter is 0, the cycle is the last data bit. Next state is IDLE, or PARITY with the macro.
  - Ready is 0 in SHIFT and PARITY; valids are ignored.
- Reset values: sdo=0, sframe=0, sid=0, done=0, req0_ready=req1_ready=0, state=IDLE, prio=0, shift register=0, counter=0.
- Reset mid-frame aborts the frame. No done pulse is produced. sframe=0 from the cycle after the reset edge. The word is lost and the requester is not re-served.
- sid holds its value after the frame until the next grant.

## Timing
- Handshake at edge E0 → bit cycles 1..WIDTH follow, with sframe=1 and sdo = data[WIDTH-1] down to data[0].
- done=1 in cycle WIDTH (no parity) or cycle WIDTH+1 (parity).
- The cycle after done is IDLE, where ready may assert.
- Minimum frame-to-frame period: WIDTH+1 cycles (WIDTH+2 with parity).
- sdo, sframe and done are registered outputs.

## Configuration
- SHIFT_TX_PARITY_EN defined:
  - After the last data bit, one PARITY cycle follows with sframe=1 and sdo = even parity, i.e. the XOR of all WIDTH data bits latched at load.
  - done is asserted in the PARITY cycle instead of the last data bit.
- Undefined: no PARITY state, no parity register, and done is asserted on the last data bit.

## Structure
- Package shift_tx_pkg:
  - state enum: IDLE, SHIFT, PARITY.
  - Requester id constants: REQ0=1'b0, REQ1=1'b1.
- Sub-module shift_tx_rr_arbiter: two-way combinational grant from valids and prio, returning the grant vector and granted id. The prio register lives in the parent.

## Test plan
- Reset: hold rstn=0 for 3 cycles with both valids high → all outputs 0 and no ready asserted; first grant after release goes to req0.
- Single frame: req0_data=4'b1011 → sdo 1,0,1,1 in cycles 1–4; sframe=1 for exactly 4 cycles; sid=0; done in cycle 4; req0_ready high in cycle 0 only.
- Contention: both valid from reset, req0=4'hA, req1=4'h5 → frame 1010 with sid=0, one idle cycle, then 0101 with sid=1. Both re-asserted afterwards → req0 wins.
- Streaming: req1_valid held high, data 4'h3 then 4'hC → frames start every 5 cycles; req0 is never granted while its valid is low.
- Reset after 2 bits of 4'hF → sframe=0 the following cycle, no done pulse, prio=0, req0 granted on the next IDLE.
- With SHIFT_TX_PARITY_EN: 4'b1011 → sdo 1,0,1,1 then parity bit 1; done in cycle 5; next ready in cycle 6.
